// File: rtl/prog_loader_pkg.sv
// +----------------------------------------------------------------------+
// | prog_loader_pkg : shared types and constants for the program loader  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        LEN   = 3'd2,
        LOAD  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_MAGIC = 2'd1;
    localparam logic [1:0] ERR_LEN   = 2'd2;
    localparam logic [1:0] ERR_CSUM  = 2'd3;

    localparam logic [31:0] MAGIC_DEFAULT = 32'h4D495053;

    // States in which a frame is in flight and bytes are consumed.
    function automatic logic accepts_bytes(input state_t s);
        return (s == SYNC) || (s == LEN) || (s == LOAD) || (s == CHECK);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_byte_assembler.sv
// +----------------------------------------------------------------------+
// | prog_loader_byte_assembler : byte handshake, little-endian word pack |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module prog_loader_byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic        w_take;

    assign w_take = en_i && rx_valid_i;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = 2'd0;
            shift_d = 24'd0;
        end else if (w_take) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    shift_d[7:0]   = rx_data_i;
                2'd1:    shift_d[15:8]  = rx_data_i;
                2'd2:    shift_d[23:16] = rx_data_i;
                default: shift_d        = shift_q;
            endcase
        end
    end

    // The fourth byte is forwarded straight through so the FSM sees the
    // complete word on the same edge that accepts it.
    assign word_o       = {rx_data_i, shift_q};
    assign word_valid_o = w_take && !clear_i && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// +----------------------------------------------------------------------+
// | prog_loader : validates a framed byte-stream image, fills imem       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          ADDR_W = 8,
    parameter logic [31:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       csum_q, csum_d;
    logic              we_q, we_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       w_word;
    logic              w_word_valid;
    logic              w_restart;
    logic              w_rx_ready;

    assign w_rx_ready = accepts_bytes(state_q);
    assign w_restart  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));

    prog_loader_byte_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (w_restart),
        .en_i         (w_rx_ready),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = SYNC;
            end
            SYNC: begin
                if (w_word_valid) begin
                    if (w_word == MAGIC) begin
                        state_d = LEN;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_MAGIC;
                    end
                end
            end
            LEN: begin
                if (w_word_valid) begin
                    if ((w_word == 32'd0) || (w_word > MAX_WORDS)) begin
                        state_d = ERROR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d  = LOAD;
                        remain_d = w_word[ADDR_W:0];
                        idx_d    = '0;
                        csum_d   = 32'd0;
                    end
                end
            end
            LOAD: begin
                if (w_word_valid) begin
                    we_d     = 1'b1;
                    wdata_d  = w_word;
                    addr_d   = idx_q;
                    // idx wraps only after the final write of a full-size image.
                    idx_d    = idx_q + 1'b1;
                    csum_d   = csum_q + w_word;
                    remain_d = remain_q - 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) state_d = CHECK;
                end
            end
            CHECK: begin
                if (w_word_valid) begin
                    if (w_word == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        err_d   = ERR_CSUM;
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d = SYNC;
                    err_d   = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            remain_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            csum_q   <= 32'd0;
            we_q     <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign rx_ready   = w_rx_ready;
    assign busy       = w_rx_ready;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == DONE);
    assign cpu_run    = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign err_code   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// +----------------------------------------------------------------------+
// | tb_prog_loader : randomized frame stimulus against a frame-level model|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_prog_loader;

    localparam int          ADDR_W = 8;
    localparam int          MAXW   = 1 << ADDR_W;
    localparam logic [31:0] MAGIC  = 32'h4D495053;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic [7:0]        rx_data  = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    int total = 0;
    int bad   = 0;
    bit abort = 1'b0;

    logic [31:0]        frame[$];
    logic [ADDR_W+31:0] writes[$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) writes.push_back({imem_addr, imem_wdata});
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Frame = magic, length, n payload words, payload sum + delta.
    task automatic build_frame(input int n, input logic [31:0] magic_w,
                               input logic [31:0] len_w, input logic [31:0] delta);
        logic [31:0] sum;
        logic [31:0] w;
        sum = 32'd0;
        frame.delete();
        frame.push_back(magic_w);
        frame.push_back(len_w);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            frame.push_back(w);
            sum = sum + w;
        end
        frame.push_back(sum + delta);
    endtask

    // Outcome of a frame derived from the framing rules alone.
    task automatic predict(output int consumed, output logic [1:0] code, output int nwr);
        logic [31:0] sum;
        int n;
        sum = 32'd0;
        nwr = 0;
        if (frame[0] != MAGIC) begin
            consumed = 1; code = 2'd1;
        end else if (frame[1] == 32'd0 || frame[1] > 32'(MAXW)) begin
            consumed = 2; code = 2'd2;
        end else begin
            n = int'(frame[1]);
            for (int i = 0; i < n; i++) sum = sum + frame[2+i];
            consumed = n + 3;
            nwr      = n;
            code     = (frame[n+2] == sum) ? 2'd0 : 2'd3;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (!abort) begin
            if (gap > 0) begin
                rx_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = b;
            t = 0;
            while (!rx_ready && t < 32) begin
                @(negedge clk);
                t++;
            end
            if (!rx_ready) begin
                total++; bad++;
                $display("FAIL handshake_timeout rx_ready=%b required=1", rx_ready);
                abort    = 1'b1;
                rx_valid = 1'b0;
                start    = 1'b0;
            end else begin
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input string name, input int maxgap, input int ign_word);
        int consumed, nwr, errs;
        logic [1:0] code;
        logic [ADDR_W+31:0] exp_w;
        predict(consumed, code, nwr);
        writes.delete();
        abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start busy=%b rx_ready=%b required=1", name, busy, rx_ready);
        end
        for (int w = 0; w < consumed; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (w == ign_word && k == 0) start = 1'b1;
                send_byte(frame[w][8*k +: 8], int'($urandom_range(maxgap, 0)));
            end
        end
        rx_valid = 1'b0;
        total++;
        if (done !== (code == 2'd0) || cpu_run !== (code == 2'd0)) begin
            bad++;
            $display("FAIL %s done done=%b cpu_run=%b required=%b", name, done, cpu_run, code == 2'd0);
        end
        total++;
        if (error !== (code != 2'd0) || err_code !== code) begin
            bad++;
            $display("FAIL %s error error=%b err_code=%0d required error=%b err_code=%0d",
                     name, error, err_code, code != 2'd0, code);
        end
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after busy=%b rx_ready=%b required=0", name, busy, rx_ready);
        end
        total++;
        if (writes.size() != nwr) begin
            bad++;
            $display("FAIL %s write_count got=%0d required=%0d", name, writes.size(), nwr);
        end else begin
            errs = 0;
            for (int i = 0; i < nwr; i++) begin
                exp_w = {ADDR_W'(i), frame[2+i]};
                if (writes[i] !== exp_w) begin
                    if (errs == 0)
                        $display("FAIL %s write_data idx=%0d got=%h required=%h", name, i, writes[i], exp_w);
                    errs++;
                end
            end
            if (errs != 0) bad++;
        end
        if (nwr > 0) begin
            total++;
            if (imem_addr !== ADDR_W'(nwr - 1)) begin
                bad++;
                $display("FAIL %s final_addr got=%0d required=%0d", name, imem_addr, nwr - 1);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({rx_ready, imem_we, cpu_run, busy, done, error, err_code, imem_addr, imem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs rdy=%b we=%b run=%b busy=%b done=%b err=%b code=%0d addr=%0d wdata=%h required all 0",
                     rx_ready, imem_we, cpu_run, busy, done, error, err_code, imem_addr, imem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle busy=%b rx_ready=%b required=0", busy, rx_ready);
        end
    endtask

    task automatic test_good_frame();
        logic [31:0] p0, p1, p2;
        p0 = 32'h20080005; p1 = 32'h20090003; p2 = 32'h01095020;
        frame.delete();
        frame.push_back(MAGIC);
        frame.push_back(32'd3);
        frame.push_back(p0);
        frame.push_back(p1);
        frame.push_back(p2);
        frame.push_back(p0 + p1 + p2);
        run_frame("good_frame", 0, -1);
    endtask

    task automatic test_bad_magic();
        build_frame(3, 32'h4D495054, 32'd3, 32'd0);
        run_frame("bad_magic", 2, -1);
        build_frame(4, MAGIC, 32'd4, 32'd0);
        run_frame("after_bad_magic", 2, -1);
    endtask

    task automatic test_bad_len();
        build_frame(2, MAGIC, 32'd0, 32'd0);
        run_frame("len_zero", 1, -1);
        build_frame(2, MAGIC, 32'(MAXW + 1), 32'd0);
        run_frame("len_over", 1, -1);
    endtask

    task automatic test_max_len();
        build_frame(MAXW, MAGIC, 32'(MAXW), 32'd0);
        run_frame("len_max", 0, -1);
    endtask

    task automatic test_bad_csum();
        build_frame(5, MAGIC, 32'd5, 32'd1);
        run_frame("bad_csum", 3, -1);
    endtask

    task automatic test_gaps();
        int n;
        for (int it = 0; it < 3; it++) begin
            n = int'($urandom_range(12, 1));
            build_frame(n, MAGIC, 32'(n), 32'd0);
            run_frame("gaps_random", 5, -1);
            run_frame("gaps_none", 0, -1);
        end
    endtask

    task automatic test_reset_mid_load();
        build_frame(3, MAGIC, 32'd3, 32'd0);
        writes.delete();
        abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) send_byte(frame[w][8*k +: 8], 0);
        send_byte(frame[3][7:0], 0);
        send_byte(frame[3][15:8], 0);
        rx_valid = 1'b0;
        total++;
        if (writes.size() != 1) begin
            bad++;
            $display("FAIL rst_mid_first_write got=%0d required=1", writes.size());
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({rx_ready, imem_we, cpu_run, busy, done, error, err_code, imem_addr, imem_wdata} !== '0) begin
            bad++;
            $display("FAIL rst_mid_async rdy=%b we=%b run=%b busy=%b done=%b err=%b code=%0d addr=%0d wdata=%h required all 0",
                     rx_ready, imem_we, cpu_run, busy, done, error, err_code, imem_addr, imem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_frame(3, MAGIC, 32'd3, 32'd0);
        run_frame("after_mid_reset", 2, -1);
    endtask

    task automatic test_start_ignored();
        build_frame(4, MAGIC, 32'd4, 32'd0);
        run_frame("start_in_load", 2, 3);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_magic();
        test_bad_len();
        test_max_len();
        test_bad_csum();
        test_gaps();
        test_reset_mid_load();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
